// File: rtl/link_recovery_ctrl.sv
// link_recovery_ctrl: GTP/deserializer bring-up and recovery sequencer on clk160.
// Define LINK_RECOVERY_PAD_MON_EN to include the pad checker in lock, drop and error monitoring.
module link_recovery_ctrl #(
  parameter int GT_RST_CYC    = 16,
  parameter int GT_DONE_TO    = 1024,
  parameter int DESER_RST_CYC = 8,
  parameter int LOCK_TO       = 4096,
  parameter int DROP_FILT     = 4,
  parameter int ERR_THRESH    = 3,
  parameter int ERR_WIN       = 1024,
  parameter int MAX_RETRY     = 7
) (
  input  logic       clk160,
  input  logic       reset,
  input  logic       enable,
  input  logic       force_relink,
  input  logic       gt_reset_done,
  input  logic       strip_linked,
  input  logic       pad_linked,
  input  logic [4:0] strip_err_cnt,
  input  logic [4:0] pad_err_cnt,
  output logic       gtp_soft_reset,
  output logic       deser_reset,
  output logic       link_up,
  output logic       link_failed,
  output logic [2:0] retry_cnt,
  output logic [2:0] ctrl_state
);
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GT_RST    = 3'd1,
    GT_WAIT   = 3'd2,
    DESER_RST = 3'd3,
    LOCK_WAIT = 3'd4,
    RUNNING   = 3'd5,
    FAILED    = 3'd6
  } state_t;
  localparam logic [15:0] GT_RST_LAST = 16'(GT_RST_CYC - 1);
  localparam logic [15:0] DONE_LAST   = 16'(GT_DONE_TO - 1);
  localparam logic [15:0] DESER_LAST  = 16'(DESER_RST_CYC - 1);
  localparam logic [15:0] LOCK_LAST   = 16'(LOCK_TO - 1);
  localparam logic [15:0] WIN_LAST    = 16'(ERR_WIN - 1);
  localparam logic [7:0]  DROP_LAST   = 8'(DROP_FILT - 1);
  localparam logic [7:0]  THRESH      = 8'(ERR_THRESH);
  localparam logic [2:0]  MAX_R       = 3'(MAX_RETRY);
  state_t      state, nxt;
  logic [15:0] timer;
  logic [7:0]  drop_cnt, err_acc, acc_sum;
  logic [8:0]  raw_sum;
  logic [4:0]  prev_strip, d_strip, d_pad;
  logic        linked, timeout, drop_hit, err_hit, win_end, retry, restart;
`ifdef LINK_RECOVERY_PAD_MON_EN
  logic [4:0]  prev_pad;
  assign linked = strip_linked & pad_linked;
  assign d_pad  = pad_err_cnt - prev_pad;
  always_ff @(posedge clk160) prev_pad <= reset ? 5'd0 : pad_err_cnt;
`else
  logic unused_pad;
  assign unused_pad = ^{pad_linked, pad_err_cnt};
  assign linked     = strip_linked;
  assign d_pad      = 5'd0;
`endif
  // Counter deltas are taken mod 32 so wrapping error counters still count.
  assign d_strip  = strip_err_cnt - prev_strip;
  assign raw_sum  = {1'b0, err_acc} + {4'b0, d_strip} + {4'b0, d_pad};
  assign acc_sum  = raw_sum[8] ? 8'hFF : raw_sum[7:0];
  assign timeout  = (state == GT_WAIT && !gt_reset_done && timer == DONE_LAST) ||
                    (state == LOCK_WAIT && !linked && timer == LOCK_LAST);
  assign drop_hit = state == RUNNING && !linked && drop_cnt == DROP_LAST;
  assign err_hit  = state == RUNNING && acc_sum >= THRESH;
  assign win_end  = state == RUNNING && timer == WIN_LAST;
  assign retry    = timeout | drop_hit | err_hit;
  assign restart  = state != IDLE && force_relink;
  assign ctrl_state = state;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = GT_RST;
      GT_RST:    nxt = timer == GT_RST_LAST ? GT_WAIT : GT_RST;
      GT_WAIT:   nxt = gt_reset_done ? DESER_RST : GT_WAIT;
      DESER_RST: nxt = timer == DESER_LAST ? LOCK_WAIT : DESER_RST;
      LOCK_WAIT: nxt = linked ? RUNNING : LOCK_WAIT;
      default:   nxt = state;
    endcase
    if (retry) nxt = retry_cnt == MAX_R ? FAILED : GT_RST;
    if (restart) nxt = GT_RST;
    if (!enable) nxt = IDLE;
  end
  // The running timer doubles as the error-window counter while in RUNNING.
  always_ff @(posedge clk160) begin
    if (reset) begin
      state          <= IDLE;
      timer          <= '0;
      drop_cnt       <= '0;
      err_acc        <= '0;
      prev_strip     <= '0;
      retry_cnt      <= '0;
      gtp_soft_reset <= 1'b0;
      deser_reset    <= 1'b1;
      link_up        <= 1'b0;
      link_failed    <= 1'b0;
    end else begin
      state          <= nxt;
      timer          <= (nxt != state || restart || win_end) ? '0 : timer + 16'd1;
      drop_cnt       <= (state == RUNNING && nxt == RUNNING && !linked) ? drop_cnt + 8'd1 : '0;
      err_acc        <= (state == RUNNING && nxt == RUNNING && !win_end) ? acc_sum : '0;
      prev_strip     <= strip_err_cnt;
      retry_cnt      <= (!enable || restart) ? '0 :
                        retry ? (retry_cnt == MAX_R ? retry_cnt : retry_cnt + 3'd1) :
                        win_end ? '0 : retry_cnt;
      gtp_soft_reset <= nxt == GT_RST;
      deser_reset    <= !(nxt == LOCK_WAIT || nxt == RUNNING);
      link_up        <= nxt == RUNNING;
      link_failed    <= nxt == FAILED;
    end
  end
endmodule

// File: tb/tb_link_recovery_ctrl.sv
// tb_link_recovery_ctrl: table and scoreboard checks of link_recovery_ctrl sequencing.
module tb_link_recovery_ctrl;
  logic       clk160 = 1'b0;
  logic       reset, enable, force_relink, gt_reset_done, strip_linked, pad_linked;
  logic [4:0] strip_err_cnt, pad_err_cnt;
  logic       gtp_soft_reset, deser_reset, link_up, link_failed;
  logic [2:0] retry_cnt, ctrl_state;
  int         n_checks = 0;
  int         n_fail = 0;
  int         n;
  int         cnt;
  typedef struct {
    string      nm;
    logic [2:0] st;
    logic       up, fail, gsr, drst;
    logic [2:0] rc;
  } exp_t;
  typedef struct {
    logic       sl;
    logic [2:0] st;
    logic       up, gsr, drst;
    logic [2:0] rc;
  } vec_t;
  exp_t sb[$];
  vec_t drop_tbl[8];
  link_recovery_ctrl dut (
    .clk160(clk160), .reset(reset), .enable(enable), .force_relink(force_relink),
    .gt_reset_done(gt_reset_done), .strip_linked(strip_linked), .pad_linked(pad_linked),
    .strip_err_cnt(strip_err_cnt), .pad_err_cnt(pad_err_cnt),
    .gtp_soft_reset(gtp_soft_reset), .deser_reset(deser_reset), .link_up(link_up),
    .link_failed(link_failed), .retry_cnt(retry_cnt), .ctrl_state(ctrl_state)
  );
  always #5 clk160 = ~clk160;
  task automatic tick();
    @(posedge clk160);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic check_sb();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.nm, ".state"}, ctrl_state, e.st);
      chk({e.nm, ".link_up"}, link_up, e.up);
      chk({e.nm, ".link_failed"}, link_failed, e.fail);
      chk({e.nm, ".gtp_soft_reset"}, gtp_soft_reset, e.gsr);
      chk({e.nm, ".deser_reset"}, deser_reset, e.drst);
      chk({e.nm, ".retry_cnt"}, retry_cnt, e.rc);
    end
  endtask
  task automatic push(input string nm, input logic [2:0] st, input logic up, input logic fail,
                      input logic gsr, input logic drst, input logic [2:0] rc);
    exp_t e;
    e = '{nm, st, up, fail, gsr, drst, rc};
    sb.push_back(e);
  endtask
  task automatic tick_exp(input string nm, input logic [2:0] st, input logic up, input logic fail,
                          input logic gsr, input logic drst, input logic [2:0] rc);
    push(nm, st, up, fail, gsr, drst, rc);
    tick();
    check_sb();
  endtask
  task automatic wait_state(input string nm, input logic [2:0] s, input int budget, output int cyc);
    cyc = 0;
    while (ctrl_state !== s && cyc < budget) begin
      tick();
      cyc++;
    end
    chk(nm, ctrl_state, s);
  endtask
  initial begin
    drop_tbl[0] = '{1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 3'd0};
    drop_tbl[1] = '{1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 3'd0};
    drop_tbl[2] = '{1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 3'd0};
    drop_tbl[3] = '{1'b1, 3'd5, 1'b1, 1'b0, 1'b0, 3'd0};
    drop_tbl[4] = '{1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 3'd0};
    drop_tbl[5] = '{1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 3'd0};
    drop_tbl[6] = '{1'b0, 3'd5, 1'b1, 1'b0, 1'b0, 3'd0};
    drop_tbl[7] = '{1'b0, 3'd1, 1'b0, 1'b1, 1'b1, 3'd1};
    reset = 1; enable = 0; force_relink = 0; gt_reset_done = 0;
    strip_linked = 0; pad_linked = 0; strip_err_cnt = 0; pad_err_cnt = 0;
    tick(); tick();
    tick_exp("reset", 3'd0, 0, 0, 0, 1, 3'd0);
    // bring-up
    reset = 0; enable = 1;
    tick_exp("enable", 3'd1, 0, 0, 1, 1, 3'd0);
    cnt = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!gtp_soft_reset) break;
      cnt++;
    end
    chk("gsr_len", cnt, 16);
    chk("gt_wait", ctrl_state, 3'd2);
    for (int i = 0; i < 4; i++) tick_exp("gt_wait_hold", 3'd2, 0, 0, 0, 1, 3'd0);
    gt_reset_done = 1;
    tick_exp("deser_enter", 3'd3, 0, 0, 0, 1, 3'd0);
    for (int i = 0; i < 7; i++) tick_exp("deser_hold", 3'd3, 0, 0, 0, 1, 3'd0);
    tick_exp("lock_enter", 3'd4, 0, 0, 0, 0, 3'd0);
    for (int i = 0; i < 19; i++) tick_exp("lock_hold", 3'd4, 0, 0, 0, 0, 3'd0);
    strip_linked = 1; pad_linked = 1;
    tick_exp("running", 3'd5, 1, 0, 0, 0, 3'd0);
    // drop filter table
    for (int i = 0; i < 8; i++) begin
      strip_linked = drop_tbl[i].sl;
      tick_exp($sformatf("drop%0d", i), drop_tbl[i].st, drop_tbl[i].up, 1'b0,
               drop_tbl[i].gsr, drop_tbl[i].drst, drop_tbl[i].rc);
    end
    // error wrap inside one window
    strip_linked = 1; strip_err_cnt = 5'd30;
    wait_state("rerun1", 3'd5, 300, n);
    strip_err_cnt = 5'd31;
    tick_exp("wrap_a", 3'd5, 1, 0, 0, 0, 3'd1);
    strip_err_cnt = 5'd0;
    tick_exp("wrap_b", 3'd5, 1, 0, 0, 0, 3'd1);
    pad_err_cnt = 5'd1;
`ifdef LINK_RECOVERY_PAD_MON_EN
    tick_exp("wrap_trig", 3'd1, 0, 0, 1, 1, 3'd2);
`else
    tick_exp("wrap_pad_ignored", 3'd5, 1, 0, 0, 0, 3'd1);
    strip_err_cnt = 5'd1;
    tick_exp("wrap_trig", 3'd1, 0, 0, 1, 1, 3'd2);
`endif
    // same errors split across two windows
    wait_state("rerun2", 3'd5, 300, n);
    strip_err_cnt = strip_err_cnt + 5'd1;
    tick_exp("win_e1", 3'd5, 1, 0, 0, 0, 3'd2);
    strip_err_cnt = strip_err_cnt + 5'd1;
    tick_exp("win_e2", 3'd5, 1, 0, 0, 0, 3'd2);
    for (int i = 0; i < 1021; i++) tick();
    push("win_last", 3'd5, 1, 0, 0, 0, 3'd2);
    check_sb();
    tick_exp("win_clean", 3'd5, 1, 0, 0, 0, 3'd0);
    pad_err_cnt = pad_err_cnt + 5'd1;
    tick_exp("win2_e3", 3'd5, 1, 0, 0, 0, 3'd0);
    // force_relink from RUNNING, then enable=0 beats force_relink in LOCK_WAIT
    force_relink = 1;
    tick_exp("force_run", 3'd1, 0, 0, 1, 1, 3'd0);
    force_relink = 0; strip_linked = 0;
    wait_state("to_lock", 3'd4, 300, n);
    enable = 0; force_relink = 1;
    tick_exp("prio_idle", 3'd0, 0, 0, 0, 1, 3'd0);
    force_relink = 0; enable = 1;
    tick_exp("restart", 3'd1, 0, 0, 1, 1, 3'd0);
    tick(); tick();
    reset = 1;
    tick_exp("mid_reset", 3'd0, 0, 0, 0, 1, 3'd0);
    reset = 0;
    // pad_linked low: lock depends on the pad monitor build option
    strip_linked = 1; pad_linked = 0;
    wait_state("lock_pad0", 3'd4, 300, n);
`ifdef LINK_RECOVERY_PAD_MON_EN
    wait_state("lock_timeout", 3'd1, 5000, n);
    chk("lock_to_cycles", n, 4096);
    push("lock_retry", 3'd1, 0, 0, 1, 1, 3'd1);
    check_sb();
`else
    tick_exp("pad_ignored_run", 3'd5, 1, 0, 0, 0, 3'd0);
`endif
    // GT_DONE timeouts exhaust retries
    gt_reset_done = 0; force_relink = 1;
    tick_exp("fail_start", 3'd1, 0, 0, 1, 1, 3'd0);
    force_relink = 0;
    wait_state("to_failed", 3'd6, 9000, n);
    chk("fail_cycles", n, 8320);
    push("failed", 3'd6, 0, 1, 0, 1, 3'd7);
    check_sb();
    for (int i = 0; i < 3; i++) tick_exp("failed_hold", 3'd6, 0, 1, 0, 1, 3'd7);
    force_relink = 1;
    tick_exp("fail_relink", 3'd1, 0, 0, 1, 1, 3'd0);
    force_relink = 0; enable = 0;
    tick_exp("disable", 3'd0, 0, 0, 0, 1, 3'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/link_recovery_ctrl.md
Name: link_recovery_ctrl

Overview:
- Sequences bring-up and recovery of the GTP receive link and the strip/pad deserializers on the clk160 domain.
- Drives the GTP soft reset and the deserializer reset (reset_160M).
- Watches the checker status (linked flags, 5-bit error counters) and re-runs the reset sequence on link loss or an excessive error rate.
- Declares permanent failure after a bounded number of retries.

Parameters:
- GT_RST_CYC, 16: cycles gtp_soft_reset is held high.
- GT_DONE_TO, 1024: cycles to wait for gt_reset_done before a retry.
- DESER_RST_CYC, 8: cycles deser_reset is held high.
- LOCK_TO, 4096: cycles to wait for both linked flags before a retry.
- DROP_FILT, 4: consecutive cycles a linked flag must be low to count as a link drop.
- ERR_THRESH, 3: errors accumulated within one window that trigger recovery.
- ERR_WIN, 1024: length of the error window in cycles; also the clean-run time that clears retry_cnt.
- MAX_RETRY, 7: retries allowed before entering FAILED (must fit in 3 bits).

Ports:
- clk160  in  1  system clock, 160 MHz
- reset  in  1  synchronous, active-high reset
- enable  in  1  level; 0 forces IDLE
- force_relink  in  1  single-cycle request to restart the sequence
- gt_reset_done  in  1  GTP receive reset complete
- strip_linked  in  1  strip checker locked
- pad_linked  in  1  pad checker locked
- strip_err_cnt  in  5  strip checker error counter, free-running, wraps
- pad_err_cnt  in  5  pad checker error counter, free-running, wraps
- gtp_soft_reset  out  1  to GTP soft reset input
- deser_reset  out  1  to deserializer reset_160M
- link_up  out  1  high only in RUNNING
- link_failed  out  1  high only in FAILED
- retry_cnt  out  3  retries since the last clean run
- ctrl_state  out  3  current state code

Behaviour:
- Clock and reset: one clock, clk160. Reset is synchronous and active-high. All outputs are registered.
- Reset values: state IDLE, gtp_soft_reset 0, deser_reset 1, link_up 0, link_failed 0, retry_cnt 0, all internal counters 0.
- State codes: IDLE 0, GT_RST 1, GT_WAIT 2, DESER_RST 3, LOCK_WAIT 4, RUNNING 5, FAILED 6.
- IDLE:
  - deser_reset 1.
  - enable=1 moves to GT_RST on the next cycle.
- GT_RST:
  - gtp_soft_reset 1 for exactly GT_RST_CYC cycles, deser_reset 1.
  - Then moves to GT_WAIT.
- GT_WAIT:
  - gt_reset_done=1 moves to DESER_RST.
  - GT_DONE_TO cycles without it triggers a retry.
- DESER_RST:
  - deser_reset 1 for exactly DESER_RST_CYC cycles.
  - Then moves to LOCK_WAIT with deser_reset 0.
- LOCK_WAIT:
  - strip_linked and pad_linked both 1 in the same cycle moves to RUNNING.
  - LOCK_TO cycles without that triggers a retry.
- RUNNING, link_up 1:
  - Link drop: either linked flag low for DROP_FILT consecutive cycles triggers a retry. Glitches shorter than DROP_FILT are ignored and reset the drop counter.
  - Error delta: each cycle, delta = (err_cnt − prev_err_cnt) mod 32, computed per checker. Both deltas are added to a saturating 8-bit accumulator, and prev_err_cnt is then updated.
  - prev_err_cnt is loaded from the inputs on RUNNING entry, so that cycle contributes no delta.
  - Error trigger: accumulator ≥ ERR_THRESH triggers a retry.
  - Window: the accumulator clears every ERR_WIN cycles.
  - Clean window: retry_cnt clears to 0 when a window completes with no trigger.
  - A drop and an error trigger in the same cycle cause one retry only.
- Retry action:
  - If retry_cnt == MAX_RETRY, go to FAILED.
  - Otherwise retry_cnt += 1, go to GT_RST, and clear all timers.
  - link_up drops in the same cycle the state leaves RUNNING.
- FAILED:
  - link_failed 1, deser_reset 1, gtp_soft_reset 0.
  - Holds until force_relink or enable=0.
- force_relink in any non-IDLE state: retry_cnt ← 0, go to GT_RST.
- enable=0 in any state: go to IDLE and clear retry_cnt. This has priority over force_relink and over all triggers.
- Reset asserted mid-sequence returns to the reset values on the next edge. No partial pulse continues.

Optional Feature:
- Macro LINK_RECOVERY_PAD_MON_EN.
- Defined: pad_linked and pad_err_cnt take part in the LOCK_WAIT condition, drop detection and error accumulation, exactly as described above.
- Undefined:
  - pad inputs are ignored (no logic reads them).
  - LOCK_WAIT requires strip_linked only.
  - Drop detection and error accumulation use the strip inputs only.
  - Port list is unchanged.

Test Plan:
- Bring-up: enable=1 after reset; gt_reset_done rises 5 cycles after GT_RST ends; both linked rise 20 cycles after DESER_RST. Required: gtp_soft_reset high exactly 16 cycles, deser_reset high through the end of DESER_RST, link_up=1, ctrl_state=5, retry_cnt=0.
- Drop filter: in RUNNING, strip_linked low for 3 cycles → stays RUNNING. Low for 4 cycles → GT_RST, retry_cnt=1, link_up 0 in the transition cycle.
- Error wrap: strip_err_cnt steps 30→31→0 while pad_err_cnt steps 0→1 within one window (accumulator 3) → retry. Same steps spread over two windows → no retry, and retry_cnt clears at the clean window end.
- Failure: gt_reset_done held 0 → 8 GT_DONE_TO timeouts → FAILED, link_failed=1, retry_cnt=7. Then force_relink pulse → GT_RST, retry_cnt=0.
- Priority: enable=0 and force_relink in the same cycle during LOCK_WAIT → IDLE. Synchronous reset asserted mid-GT_RST → gtp_soft_reset 0 on the next edge.
- Macro off: pad_linked tied 0 → still reaches RUNNING. Macro on: same stimulus → LOCK_TO timeout retry.
